instr_stream_source: RTL and testbench
======================================

Name: instr_stream_source

Overview:
- On-chip instruction source for the processor core: the producing end of the 20-bit `data` instruction stream that the core consumes one word per clock.
- Holds a small program buffer loaded word-by-word, then replays it to the core on `start`, one word per clock.
- Supports stall, end-of-program signalling, and replay.
- Replaces file-driven stimulus on hardware targets.

Parameters:
- DATA_W, 20, instruction word width; matches core `data` input.
- DEPTH, 16, program buffer entries.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- load_en  input  1  append load_word to buffer (IDLE only)
- load_word  input  DATA_W  instruction to append
- clear  input  1  empty the buffer (IDLE only)
- start  input  1  begin replay (IDLE only)
- stall  input  1  hold the stream this cycle
- data  output  DATA_W  instruction word to core; registered
- data_valid  output  1  data holds a newly issued word this cycle
- busy  output  1  state is RUN or DONE
- done  output  1  one-cycle pulse after last word issued
- overflow  output  1  sticky: load attempted while buffer full
- prog_len  output  ADDR_W+1  number of words loaded (0..DEPTH)
- pc  output  ADDR_W  index of next word to issue

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values (all outputs, all registers except buffer contents): state=IDLE, data=0, data_valid=0, busy=0, done=0, overflow=0, prog_len=0, pc=0.
  - Buffer contents are not reset; they are unreachable once prog_len=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - Per-edge priority: clear > start > load_en.
  - clear: prog_len<=0, overflow<=0, pc<=0.
  - start with prog_len>0: pc<=0, state<=RUN.
  - start with prog_len=0: ignored; stays IDLE with no pulse.
  - load_en with prog_len<DEPTH: mem[prog_len]<=load_word, prog_len<=prog_len+1.
  - load_en with prog_len=DEPTH: word dropped, overflow<=1 (sticky until clear or rst).
  - A load_en asserted on the same edge as start or clear is discarded without setting overflow.
  - data<=0, data_valid<=0.
- RUN:
  - stall=0: data<=mem[pc], data_valid<=1, pc<=pc+1.
    - If pc==prog_len-1, state<=DONE and pc<=0; no wrap into stale entries.
  - stall=1: data holds its previous value, data_valid<=0, pc unchanged.
  - load_en and clear are ignored; overflow is unaffected.
  - start is ignored; no restart mid-run.
- DONE: data_valid<=0, data<=0, done<=1 for exactly one cycle, then state<=IDLE.
  - stall is ignored in DONE.
- busy=1 in RUN and DONE.
- Latency:
  - start sampled at edge k; word0 appears after edge k+1; word i after edge k+1+i with no stalls.
  - Each stall cycle adds one cycle.
  - done rises after edge k+1+prog_len.
- Replay: after DONE→IDLE the buffer is retained; a new start replays an identical stream.
- Full buffer (prog_len=DEPTH): all DEPTH words issue; pc returns to 0 on completion.
  - prog_len is ADDR_W+1 bits, so DEPTH is representable.
- rst mid-RUN: stream stops immediately (data=0, data_valid=0); prog_len=0, so the program must be reloaded.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then load 3 words 0x12345, 0xABCDE, 0x00001; start at edge k → data_valid=1 after edges k+1..k+3 with those words in order; done=1 after edge k+4 only; busy falls after edge k+5; pc=0.
2. Load 2 words, start, hold stall=1 for 2 cycles right after first word → word0, two cycles data_valid=0 with data held at word0, then word1, then done pulse; total 5 cycles from start to done.
3. Load 16 words 0x00000..0x0000F, then load 0xFFFFF → prog_len=16, overflow=1; replay issues exactly 0x00000..0x0000F; clear → prog_len=0, overflow=0.
4. start with prog_len=0 → busy stays 0, no data_valid, no done; simultaneous clear+start with prog_len=3 → prog_len=0, no run.
5. Mid-RUN load_en=1 with 0x77777 → ignored, prog_len unchanged; after done, start again → identical stream replayed.
6. Assert rst asynchronously between edges during word 2 of 5 → data=0, data_valid=0, busy=0, prog_len=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_stream_source.sv
// ---------------------------------------------------------------------------
// InstrStreamSource
//
// On-chip instruction source for the processor core. A small program buffer
// is filled one word at a time while idle, then replayed to the core one word
// per clock after a start request. The buffer is kept after a run so the same
// program can be replayed by another start.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous, active-high reset
//   load_en    - append load_word to the buffer (idle only)
//   load_word  - instruction word to append
//   clear      - empty the buffer and clear overflow (idle only)
//   start      - begin replay of the loaded program (idle only)
//   stall      - hold the stream for this cycle
//   data       - instruction word to the core (registered)
//   data_valid - data holds a newly issued word this cycle
//   busy       - a replay is in progress (running or finishing)
//   done       - one-cycle pulse after the last word has been issued
//   overflow   - sticky flag: a load was attempted with the buffer full
//   prog_len   - number of words loaded (0..DEPTH)
//   pc         - index of the next word to issue
// ---------------------------------------------------------------------------
module instr_stream_source #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_word,
  input  logic              clear,
  input  logic              start,
  input  logic              stall,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t              state_q;
  logic [DATA_W-1:0]   data_q;
  logic                dataValid_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;
  logic [ADDR_W:0]     progLen_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                memWrite_d;

  // A load is only accepted while idle, when neither clear nor start claims
  // the same edge, and while there is still room in the buffer.
  assign memWrite_d = (state_q == IDLE) && load_en && !clear && !start &&
                      (progLen_q != LEN_MAX);

  // Program buffer storage. It is deliberately not reset: once prog_len is
  // zero the stale contents can never be issued.
  always_ff @(posedge clk) begin
    if (memWrite_d) begin
      mem[progLen_q[ADDR_W-1:0]] <= load_word;
    end
  end

  // Main controller. busy and done are registered copies of the state seen
  // on the previous cycle, so busy stays high through the done pulse and
  // drops one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dataValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      progLen_q   <= '0;
      pc_q        <= '0;
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          data_q      <= '0;
          dataValid_q <= 1'b0;
          if (clear) begin
            progLen_q  <= '0;
            overflow_q <= 1'b0;
            pc_q       <= '0;
          end else if (start) begin
            if (progLen_q != '0) begin
              pc_q    <= '0;
              state_q <= RUN;
            end
          end else if (load_en) begin
            if (progLen_q == LEN_MAX) begin
              overflow_q <= 1'b1;
            end else begin
              progLen_q <= progLen_q + LEN_ONE;
            end
          end
        end
        RUN: begin
          if (stall) begin
            dataValid_q <= 1'b0;
          end else begin
            data_q      <= mem[pc_q];
            dataValid_q <= 1'b1;
            // Stop at the last loaded word instead of wrapping into stale entries.
            if ({1'b0, pc_q} == progLen_q - LEN_ONE) begin
              pc_q    <= '0;
              state_q <= DONE;
            end else begin
              pc_q <= pc_q + PC_ONE;
            end
          end
        end
        DONE: begin
          data_q      <= '0;
          dataValid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = dataValid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign prog_len   = progLen_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_instr_stream_source.sv
// ---------------------------------------------------------------------------
// tb_instr_stream_source
//
// Self-checking bench for instr_stream_source. The bench keeps its own view
// of the program as a queue of loaded words plus an overflow flag, and
// predicts the issued stream, stall behaviour and done timing from that.
// ---------------------------------------------------------------------------
module tb_instr_stream_source;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [19:0] load_word;
  logic        clear;
  logic        start;
  logic        stall;
  logic [19:0] data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  prog_len;
  logic [3:0]  pc;

  int checks;
  int fails;

  logic [19:0] model[$];
  bit          modelOvf;

  instr_stream_source #(
    .DATA_W(20),
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_word (load_word),
    .clear     (clear),
    .start     (start),
    .stall     (stall),
    .data      (data),
    .data_valid(data_valid),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .prog_len  (prog_len),
    .pc        (pc)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge, where outputs are sampled
  // and the next set of inputs is driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one word through the port and mirror it into the bench program model.
  task automatic applyStimulus(input logic [19:0] w);
    load_en   = 1'b1;
    load_word = w;
    tick();
    load_en = 1'b0;
    if (model.size() < 16) model.push_back(w);
    else modelOvf = 1'b1;
  endtask

  // Empty the buffer through the port and in the model.
  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    modelOvf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    model.delete();
    modelOvf = 1'b0;
    checks++; if (data !== 20'h0) begin fails++; $display("[TB] FAIL reset_data got=%h exp=0", data); end
    checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (prog_len !== 5'd0) begin fails++; $display("[TB] FAIL reset_prog_len got=%0d exp=0", prog_len); end
    checks++; if (pc !== 4'd0) begin fails++; $display("[TB] FAIL reset_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_basic_stream();
    applyStimulus(20'h12345);
    applyStimulus(20'hABCDE);
    applyStimulus(20'h00001);
    checks++; if (prog_len !== 5'd3) begin fails++; $display("[TB] FAIL basic_len got=%0d exp=3", prog_len); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_start_valid got=%b exp=0", data_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (data_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid[%0d] got=%b exp=1", i, data_valid); end
      checks++; if (data !== model[i]) begin fails++; $display("[TB] FAIL basic_data[%0d] got=%h exp=%h", i, data, model[i]); end
      checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_early_done[%0d] got=%b exp=0", i, done); end
      checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy[%0d] got=%b exp=1", i, busy); end
    end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL basic_done got=%b exp=1", done); end
    checks++; if (data_valid !== 1'b0 || data !== 20'h0) begin fails++; $display("[TB] FAIL basic_done_data got=%b/%h exp=0/0", data_valid, data); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_done got=%b exp=1", busy); end
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_fall got=%b exp=0", busy); end
    checks++; if (pc !== 4'd0) begin fails++; $display("[TB] FAIL basic_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_stall();
    logic [19:0] w0;
    logic [19:0] w1;
    w0 = 20'($urandom);
    w1 = 20'($urandom);
    doClear();
    applyStimulus(w0);
    applyStimulus(w1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (data_valid !== 1'b1 || data !== w0) begin fails++; $display("[TB] FAIL stall_word0 got=%b/%h exp=1/%h", data_valid, data, w0); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (data_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=0", i, data_valid); end
      checks++; if (data !== w0) begin fails++; $display("[TB] FAIL stall_hold[%0d] got=%h exp=%h", i, data, w0); end
      checks++; if (pc !== 4'd1) begin fails++; $display("[TB] FAIL stall_pc[%0d] got=%0d exp=1", i, pc); end
    end
    stall = 1'b0;
    tick();
    checks++; if (data_valid !== 1'b1 || data !== w1) begin fails++; $display("[TB] FAIL stall_word1 got=%b/%h exp=1/%h", data_valid, data, w1); end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL stall_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_full_overflow();
    doClear();
    for (int i = 0; i < 16; i++) applyStimulus(20'(i));
    applyStimulus(20'hFFFFF);
    checks++; if (prog_len !== 5'd16) begin fails++; $display("[TB] FAIL full_len got=%0d exp=16", prog_len); end
    checks++; if (overflow !== modelOvf) begin fails++; $display("[TB] FAIL full_overflow got=%b exp=%b", overflow, modelOvf); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (data_valid !== 1'b1 || data !== model[i]) begin fails++; $display("[TB] FAIL full_word[%0d] got=%b/%h exp=1/%h", i, data_valid, data, model[i]); end
    end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL full_done got=%b exp=1", done); end
    checks++; if (pc !== 4'd0) begin fails++; $display("[TB] FAIL full_pc got=%0d exp=0", pc); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL full_sticky got=%b exp=1", overflow); end
    tick();
    doClear();
    checks++; if (prog_len !== 5'd0) begin fails++; $display("[TB] FAIL full_clear_len got=%0d exp=0", prog_len); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL full_clear_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_empty_start();
    int badCycles;
    start = 1'b1;
    tick();
    start = 1'b0;
    badCycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || data_valid !== 1'b0 || done !== 1'b0) badCycles++;
      tick();
    end
    checks++; if (badCycles !== 0) begin fails++; $display("[TB] FAIL empty_start active_cycles got=%0d exp=0", badCycles); end
    applyStimulus(20'h11111);
    applyStimulus(20'h22222);
    applyStimulus(20'h33333);
    checks++; if (prog_len !== 5'd3) begin fails++; $display("[TB] FAIL clrstart_preload got=%0d exp=3", prog_len); end
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    model.delete();
    modelOvf = 1'b0;
    checks++; if (prog_len !== 5'd0) begin fails++; $display("[TB] FAIL clrstart_len got=%0d exp=0", prog_len); end
    badCycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b0 || data_valid !== 1'b0 || done !== 1'b0) badCycles++;
    end
    checks++; if (badCycles !== 0) begin fails++; $display("[TB] FAIL clrstart_run active_cycles got=%0d exp=0", badCycles); end
  endtask

  task automatic test_midrun_load_replay();
    logic [19:0] got[$];
    bit seenDone;
    doClear();
    for (int i = 0; i < 4; i++) applyStimulus(20'($urandom));
    for (int run = 0; run < 2; run++) begin
      got.delete();
      seenDone = 1'b0;
      start     = 1'b1;
      load_en   = (run == 0);
      load_word = 20'h77777;
      tick();
      start = 1'b0;
      for (int c = 0; c < 30 && !seenDone; c++) begin
        load_en = (run == 0) && (c < 3);
        tick();
        if (data_valid) got.push_back(data);
        if (done) seenDone = 1'b1;
      end
      load_en = 1'b0;
      checks++; if (seenDone !== 1'b1) begin fails++; $display("[TB] FAIL midrun_timeout run=%0d got=no_done exp=done", run); end
      checks++; if (prog_len !== 5'd4) begin fails++; $display("[TB] FAIL midrun_len run=%0d got=%0d exp=4", run, prog_len); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL midrun_ovf run=%0d got=%b exp=0", run, overflow); end
      checks++; if (got.size() !== 4) begin fails++; $display("[TB] FAIL midrun_count run=%0d got=%0d exp=4", run, got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
        checks++; if (got[i] !== model[i]) begin fails++; $display("[TB] FAIL midrun_word run=%0d[%0d] got=%h exp=%h", run, i, got[i], model[i]); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    doClear();
    for (int i = 0; i < 5; i++) applyStimulus(20'h00100 + 20'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (data_valid !== 1'b1 || data !== model[2]) begin fails++; $display("[TB] FAIL areset_pre got=%b/%h exp=1/%h", data_valid, data, model[2]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (data !== 20'h0 || data_valid !== 1'b0) begin fails++; $display("[TB] FAIL areset_stream got=%b/%h exp=0/0", data_valid, data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (prog_len !== 5'd0) begin fails++; $display("[TB] FAIL areset_len got=%0d exp=0", prog_len); end
    #1;
    rst = 1'b0;
    model.delete();
    modelOvf = 1'b0;
    tick();
  endtask

  // Random programs with random stalls: the bench walks its own word queue,
  // advancing only on non-stalled cycles, and expects done right after the
  // last word.
  task automatic test_random();
    for (int round = 0; round < 12; round++) begin
      int n;
      int idx;
      int guard;
      logic [19:0] last;
      doClear();
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) applyStimulus(20'($urandom));
      checks++; if (prog_len !== 5'(model.size()) || overflow !== modelOvf) begin fails++; $display("[TB] FAIL rand_load[%0d] got=%0d/%b exp=%0d/%b", round, prog_len, overflow, model.size(), modelOvf); end
      start = 1'b1;
      tick();
      start = 1'b0;
      idx   = 0;
      last  = 20'h0;
      guard = 0;
      while (idx < model.size() && guard < 200) begin
        stall = ($urandom_range(0, 2) == 0);
        tick();
        guard++;
        if (stall) begin
          checks++; if (data_valid !== 1'b0 || data !== last) begin fails++; $display("[TB] FAIL rand_stall[%0d] got=%b/%h exp=0/%h", round, data_valid, data, last); end
        end else begin
          checks++; if (data_valid !== 1'b1 || data !== model[idx]) begin fails++; $display("[TB] FAIL rand_word[%0d][%0d] got=%b/%h exp=1/%h", round, idx, data_valid, data, model[idx]); end
          last = model[idx];
          idx++;
        end
        checks++; if (pc !== 4'(idx == model.size() ? 0 : idx)) begin fails++; $display("[TB] FAIL rand_pc[%0d] got=%0d exp=%0d", round, pc, (idx == model.size() ? 0 : idx)); end
      end
      stall = 1'($urandom_range(0, 1));
      tick();
      stall = 1'b0;
      checks++; if (done !== 1'b1 || data_valid !== 1'b0) begin fails++; $display("[TB] FAIL rand_done[%0d] got=%b/%b exp=1/0", round, done, data_valid); end
      tick();
    end
  endtask

  // Test sequence: each scenario drives and checks on its own, then the
  // summary is printed.
  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_word = 20'h0;
    clear     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    modelOvf  = 1'b0;
    test_reset();
    test_basic_stream();
    test_stall();
    test_full_overflow();
    test_empty_start();
    test_midrun_load_replay();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
